// File: rtl/serial_7seg_receiver.sv
// Serial 7-segment frame receiver.
// Three asynchronous pins (data, shift clock, latch) are synchronized and
// edge-detected. Shift-clock rising edges shift data in MSB-first; a latch rising
// edge publishes the frame when exactly FRAME_BITS bits were shifted. Otherwise it
// flags a sticky error.

// Per-pin synchronizer: a STAGES-deep flop chain, reset to 0.
module serial_7seg_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] ff;

   // Shift the pin level through the chain; the last stage is the usable copy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ff <= '0;
      else        ff <= {ff[STAGES-2:0], d};
   end

   assign q = ff[STAGES-1];

endmodule

module serial_7seg_receiver #(
   parameter int NUM_DIGITS  = 6,
   parameter int SYNC_STAGES = 2,
   localparam int FRAME_BITS = 8 * NUM_DIGITS,
   localparam int CNT_W      = $clog2(FRAME_BITS + 2)
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   input  logic                  i_serial_data,
   input  logic                  i_serial_clk,
   input  logic                  i_serial_latch,
   output logic [FRAME_BITS-1:0] o_digits,
   output logic                  o_frame_valid,
   output logic                  o_frame_error,
   output logic [CNT_W-1:0]      o_bit_count
);

   localparam int NUM_PINS  = 3;
   localparam int PIN_DATA  = 0;
   localparam int PIN_SCLK  = 1;
   localparam int PIN_LATCH = 2;
   localparam int ARM_W     = $clog2(SYNC_STAGES + 2);
   localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);

   logic [NUM_PINS-1:0]   pins;
   logic [NUM_PINS-1:0]   pins_s;

   logic [ARM_W-1:0]      arm_cnt;
   logic                  armed;

   logic                  sclk_d;
   logic                  latch_d;
   logic                  sclk_rise_q;
   logic                  latch_rise_q;
   logic                  data_q;

   logic [FRAME_BITS-1:0] shift_q;
   logic [FRAME_BITS-1:0] shift_nxt;
   logic [CNT_W-1:0]      cnt_q;
   logic [CNT_W-1:0]      cnt_nxt;

   assign pins[PIN_DATA]  = i_serial_data;
   assign pins[PIN_SCLK]  = i_serial_clk;
   assign pins[PIN_LATCH] = i_serial_latch;

   // One independent synchronizer per serial pin.
   for (genvar p = 0; p < NUM_PINS; p++) begin : g_sync
      serial_7seg_sync #(.STAGES(SYNC_STAGES)) u_sync (
         .clk   (i_clk),
         .rst_n (i_reset_n),
         .d     (pins[p]),
         .q     (pins_s[p])
      );
   end

   assign armed = (arm_cnt == ARM_DONE);

   // Arming counter: edges are ignored until the sync/delay flops have settled
   // after reset. Pins already high at release then never look like a rise.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n)  arm_cnt <= '0;
      else if (!armed) arm_cnt <= arm_cnt + 1'b1;
   end

   // Delay copies plus a registered rise pulse. The extra register stage places
   // the frame update SYNC_STAGES+1 cycles after the pin is first sampled.
   // Data is registered alongside so it stays aligned with its shift edge.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         sclk_d       <= 1'b0;
         latch_d      <= 1'b0;
         sclk_rise_q  <= 1'b0;
         latch_rise_q <= 1'b0;
         data_q       <= 1'b0;
      end else begin
         sclk_d       <= pins_s[PIN_SCLK];
         latch_d      <= pins_s[PIN_LATCH];
         sclk_rise_q  <= armed & pins_s[PIN_SCLK]  & ~sclk_d;
         latch_rise_q <= armed & pins_s[PIN_LATCH] & ~latch_d;
         data_q       <= pins_s[PIN_DATA];
      end
   end

   // Apply the shift first, so a same-cycle latch checks the incremented count
   // and publishes the new bit.
   always_comb begin
      shift_nxt = shift_q;
      cnt_nxt   = cnt_q;
      if (sclk_rise_q) begin
         shift_nxt = {shift_q[FRAME_BITS-2:0], data_q};
         if (cnt_q != CNT_SAT) cnt_nxt = cnt_q + 1'b1;
      end
   end

   // Frame state: the shift register, the bit counter and the published outputs.
   // A latch restarts the count but leaves the shift register untouched.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         shift_q       <= '0;
         cnt_q         <= '0;
         o_digits      <= '0;
         o_frame_valid <= 1'b0;
         o_frame_error <= 1'b0;
      end else begin
         shift_q       <= shift_nxt;
         cnt_q         <= cnt_nxt;
         o_frame_valid <= 1'b0;
         if (latch_rise_q) begin
            cnt_q <= '0;
            if (cnt_nxt == CNT_FULL) begin
               o_digits      <= shift_nxt;
               o_frame_valid <= 1'b1;
               o_frame_error <= 1'b0;
            end else begin
               o_frame_error <= 1'b1;
            end
         end
      end
   end

   assign o_bit_count = cnt_q;

endmodule

// File: tb/tb_serial_7seg_receiver.sv
// Bench for serial_7seg_receiver (NUM_DIGITS=6, SYNC_STAGES=2).
// Expected frames and their update cycles are queued at latch time. A monitor
// pops and compares each time o_frame_valid is seen. Flag and counter checks
// are made inline.
module tb_serial_7seg_receiver;

   localparam int FB = 48;

   typedef struct {
      logic [FB-1:0] digits;
      int            cyc;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          sdata = 1'b0;
   logic          sclk = 1'b0;
   logic          slatch = 1'b0;
   logic [FB-1:0] digits;
   logic          fvalid;
   logic          ferror;
   logic [5:0]    bcount;

   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   exp_t sb[$];

   serial_7seg_receiver #(.NUM_DIGITS(6), .SYNC_STAGES(2)) dut (
      .i_clk          (clk),
      .i_reset_n      (rst_n),
      .i_serial_data  (sdata),
      .i_serial_clk   (sclk),
      .i_serial_latch (slatch),
      .o_digits       (digits),
      .o_frame_valid  (fvalid),
      .o_frame_error  (ferror),
      .o_bit_count    (bcount)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every valid pulse must match the oldest queued frame and its cycle.
   always @(negedge clk) begin
      if (fvalid === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_valid", 64'(digits), 64'hDEAD_0000_0000);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("frame_digits", 64'(digits), 64'(e.digits));
            check("frame_latency", 64'(cyc), 64'(e.cyc));
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      @(negedge clk); sdata = b;
      idle(4); sclk = 1'b1;
      idle(4); sclk = 1'b0;
      idle(4);
   endtask

   task automatic send_bits(input logic [63:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
   endtask

   // Raise the latch; a good frame is expected 4 posedges later (1 to sample, +3).
   task automatic do_latch(input bit good, input logic [FB-1:0] exp);
      @(negedge clk);
      slatch = 1'b1;
      if (good) sb.push_back('{exp, cyc + 4});
      idle(4); slatch = 1'b0;
      idle(4);
   endtask

   localparam logic [FB-1:0] FA = 48'h3F065B4F666D;
   localparam logic [FB-1:0] FC = 48'h0123456789AB;
   localparam logic [FB-1:0] FD = 48'hA5A55A5AF00F;
   localparam logic [FB-1:0] FE = 48'hDEADBEEFCAFE;

   initial begin
      idle(3);
      check("rst_digits", 64'(digits), 64'h0);
      check("rst_valid", 64'(fvalid), 64'h0);
      check("rst_error", 64'(ferror), 64'h0);
      check("rst_count", 64'(bcount), 64'h0);
      rst_n = 1'b1;
      idle(5);

      // Good frame.
      send_bits(64'(FA), 48);
      check("count_48", 64'(bcount), 64'd48);
      do_latch(1'b1, FA);
      check("a_digits", 64'(digits), 64'(FA));
      check("a_error", 64'(ferror), 64'h0);
      check("a_count", 64'(bcount), 64'h0);

      // Short frame: rejected.
      send_bits(64'h7FFF_1234_5678, 47);
      check("count_47", 64'(bcount), 64'd47);
      do_latch(1'b0, '0);
      check("short_error", 64'(ferror), 64'h1);
      check("short_digits", 64'(digits), 64'(FA));
      check("short_count", 64'(bcount), 64'h0);

      // Good frame clears the error.
      send_bits(64'(FC), 48);
      do_latch(1'b1, FC);
      check("c_error", 64'(ferror), 64'h0);
      check("c_digits", 64'(digits), 64'(FC));

      // Long frame: counter saturates at 49.
      send_bits(64'h3_FFFF_0000_FFFF, 50);
      check("count_sat", 64'(bcount), 64'd49);
      do_latch(1'b0, '0);
      check("long_error", 64'(ferror), 64'h1);
      check("long_digits", 64'(digits), 64'(FC));

      // 47 bits, then the 48th shift edge and the latch rise in the same cycle.
      send_bits(64'(FD >> 1), 47);
      @(negedge clk); sdata = 1'b1;
      idle(4);
      sclk = 1'b1; slatch = 1'b1;
      sb.push_back('{FD, cyc + 4});
      idle(4); sclk = 1'b0; slatch = 1'b0;
      idle(4);
      check("same_digits", 64'(digits), 64'(FD));
      check("same_bit0", 64'(digits[0]), 64'h1);
      check("same_error", 64'(ferror), 64'h0);
      check("same_count", 64'(bcount), 64'h0);

      // Pins held high through reset release: no edge must be seen.
      @(negedge clk); rst_n = 1'b0; sclk = 1'b1; slatch = 1'b1;
      idle(3);
      rst_n = 1'b1;
      idle(10);
      check("hold_count", 64'(bcount), 64'h0);
      check("hold_error", 64'(ferror), 64'h0);
      check("hold_digits", 64'(digits), 64'h0);
      sclk = 1'b0; slatch = 1'b0;
      idle(6);
      check("hold_count_low", 64'(bcount), 64'h0);

      // Reset mid-frame discards the partial frame.
      send_bits(64'hABCDE, 20);
      check("count_20", 64'(bcount), 64'd20);
      @(negedge clk); rst_n = 1'b0;
      idle(2);
      check("mid_rst_count", 64'(bcount), 64'h0);
      rst_n = 1'b1;
      idle(6);
      send_bits(64'(FE), 48);
      do_latch(1'b1, FE);
      check("e_digits", 64'(digits), 64'(FE));
      check("e_error", 64'(ferror), 64'h0);

      idle(10);
      check("sb_drained", 64'(sb.size()), 64'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/serial_7seg_receiver.md
SERIAL_7SEG_RECEIVER -- requirements
Module: serial_7seg_receiver

Interface
REQ-001 Parameter NUM_DIGITS, default 6: number of 8-bit segment bytes per frame; frame length FRAME_BITS = 8*NUM_DIGITS.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer flop depth per serial input, legal range 2..4.
REQ-003 i_clk  input  1  system clock; the only clock; all state on its rising edge.
REQ-004 i_reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 i_serial_data  input  1  serial data pin, asynchronous to i_clk.
REQ-006 i_serial_clk  input  1  serial shift clock pin, asynchronous to i_clk, idle low.
REQ-007 i_serial_latch  input  1  serial latch pin, asynchronous to i_clk, idle low.
REQ-008 o_digits  output  FRAME_BITS  last accepted frame; byte k = bits [8k+7:8k], byte NUM_DIGITS-1 = first byte sent.
REQ-009 o_frame_valid  output  1  one-cycle strobe, high in the cycle o_digits is updated.
REQ-010 o_frame_error  output  1  sticky flag, set by a rejected frame.
REQ-011 o_bit_count  output  $clog2(FRAME_BITS+2)  bits shifted since the last latch edge, saturating.

Function
REQ-012 Each serial input SHALL pass through its own SYNC_STAGES-flop synchronizer before any use.
REQ-013 A rising edge SHALL be detected when a synchronized signal is 1 and its one-cycle-delayed copy is 0; falling edges are ignored.
REQ-014 On a detected serial-clock rising edge, the block SHALL shift the shift register left by one bit, load synchronized data into bit 0, and increment the bit counter.
REQ-015 Data SHALL be captured MSB-first: the first bit of a FRAME_BITS frame ends at shift-register bit FRAME_BITS-1.
REQ-016 The bit counter SHALL saturate at FRAME_BITS+1; bits beyond that still shift, and the oldest bits are discarded.
REQ-017 On a detected latch rising edge with counter == FRAME_BITS, the block SHALL copy the shift register to o_digits, pulse o_frame_valid for one cycle, and clear o_frame_error.
REQ-018 On a detected latch rising edge with counter != FRAME_BITS, the block SHALL leave o_digits unchanged, hold o_frame_valid low, and set o_frame_error.
REQ-019 After any latch edge, the bit counter SHALL read 0 in the following cycle; the shift register is not cleared.
REQ-020 If serial-clock and latch rising edges are detected in the same cycle, the shift SHALL be applied first and the REQ-017/018 check SHALL use the incremented count; the data written to o_digits SHALL include the new bit.
REQ-021 Latency: o_digits/o_frame_valid SHALL update exactly SYNC_STAGES+1 i_clk cycles after the first i_clk edge that samples the latch pin high.
REQ-022 Serial pins SHALL be held at each level for at least SYNC_STAGES+1 i_clk periods; shorter pulses are not guaranteed to be detected.
REQ-023 After reset deassertion, the block SHALL suppress edge detection for SYNC_STAGES+1 cycles (arming counter), so pins already high at release produce no edge.

Reset
REQ-024 While i_reset_n is low: all synchronizer and delay flops, the shift register, the bit counter, o_digits, o_frame_valid, o_frame_error, and the arming counter SHALL be 0.
REQ-025 Reset asserted mid-frame SHALL discard the partial frame; the first frame after re-arming SHALL be received normally.

Verification
REQ-026 NUM_DIGITS=6: send 48 bits 0x3F_06_5B_4F_66_6D MSB-first, then latch -> o_digits=0x3F065B4F666D, one o_frame_valid pulse at latch-sample+3 cycles, o_frame_error=0, o_bit_count=0 afterwards.
REQ-027 Send 47 bits, then latch -> o_digits unchanged, no valid pulse, o_frame_error=1; then a good frame -> o_frame_error=0 and o_digits updated.
REQ-028 Send 50 bits, then latch -> o_bit_count read 49 before the latch, error set, o_digits unchanged.
REQ-029 After 47 bits, drive serial clock and latch high in the same i_clk cycle with data=1 -> frame accepted, o_digits bit 0 = 1.
REQ-030 Hold the latch and serial clock high through reset release -> no shift, no error, no valid; a reset asserted after 20 bits followed by a full frame -> only the new frame appears.
